// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle MIPS main control unit: state
// encodings, opcode constants, ALUOp codes (also used by the ALU control),
// datapath select codes and the control-word structure.
//
// Configuration macro: MC_ADDI_EN -- when defined, addi (001000) is a legal
// opcode; otherwise it decodes as illegal.
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

    localparam int OPCODE_W_C = 6;
    localparam int STATE_W_C  = 4;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Full datapath control word produced for each state.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       done;
    } ctrl_t;

    // True for every opcode the control unit knows how to sequence.
    function automatic logic is_legal_op(input logic [5:0] op);
        logic legal_s;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: legal_s = 1'b1;
`ifdef MC_ADDI_EN
            OP_ADDI:                              legal_s = 1'b1;
`endif
            default:                              legal_s = 1'b0;
        endcase
        return legal_s;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mc_ctrl_decode
// Purely combinational state-to-control-word decode.
//   state_i : FSM state to decode
//   ctrl_o  : datapath control word for that state (all zero for IDLE and
//             for any encoding without a defined meaning)
//
// Configuration macro: MC_ADDI_EN -- enables the ADDI_EXEC / ADDI_WB words.
// -----------------------------------------------------------------------------
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    // Map each state to its control word; unlisted fields stay zero.
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                // Speculative branch target: PC + (imm << 2)
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.done       = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
                ctrl_o.done      = 1'b1;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNC;
            end
            S_R_WB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.done      = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.done          = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
                ctrl_o.done      = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.done      = 1'b1;
            end
`endif
            default: begin
                ctrl_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
// Multicycle MIPS main control unit. Sequences fetch / decode / execute /
// memory / writeback, one state per clock, and drives the datapath enables,
// mux selects and ALUOp.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous active-high reset (returns to IDLE)
//   opcode         instruction[31:26], sampled only in DECODE
//   pc_write .. done   Moore control outputs for the current state
//   illegal_op     one-cycle pulse in DECODE for an unsupported opcode
//   state          current state, for debug
//
// The control outputs are registered: the decode of the next state is loaded
// into an output register on the same edge that loads the state register, so
// they always equal the decode of the current state with no decode glitches.
//
// Configuration macro: MC_ADDI_EN -- adds addi (DECODE->ADDI_EXEC->ADDI_WB).
// -----------------------------------------------------------------------------
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                done,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    ctrl_t               ctrl_q, ctrl_d;

    // Next-state logic; the opcode is captured in DECODE so later opcode
    // changes cannot redirect MEM_ADDR.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (op_q == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_READ:  state_d = S_MEM_WB;
            S_EXECUTE:   state_d = S_R_WB;
            S_MEM_WB,
            S_MEM_WRITE,
            S_R_WB,
            S_BRANCH,
            S_JUMP:      state_d = S_FETCH;
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
`endif
            default:     state_d = S_IDLE;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state_i (state_d),
        .ctrl_o  (ctrl_d)
    );

    // State, captured opcode and registered control word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // illegal_op must appear in the same cycle the opcode is examined.
    assign illegal_op    = (state_q == S_DECODE) && !is_legal_op(opcode);

    assign pc_write      = ctrl_q.pc_write;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign i_or_d        = ctrl_q.i_or_d;
    assign mem_read      = ctrl_q.mem_read;
    assign mem_write     = ctrl_q.mem_write;
    assign ir_write      = ctrl_q.ir_write;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign reg_dst       = ctrl_q.reg_dst;
    assign reg_write     = ctrl_q.reg_write;
    assign alu_src_a     = ctrl_q.alu_src_a;
    assign alu_src_b     = ctrl_q.alu_src_b;
    assign alu_op        = ctrl_q.alu_op;
    assign pc_source     = ctrl_q.pc_source;
    assign done          = ctrl_q.done;
    assign state         = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
// Directed, self-checking bench for mc_control_fsm. Each scenario task drives
// an opcode, walks the expected state sequence and compares state and the
// whole output vector against hand-written per-state values.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, done, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    mc_control_fsm #(.OPCODE_W(6), .STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .done          (done),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [17:0] obs_vec;
    assign obs_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, done, illegal_op};

    // Expected output vector for a state, written straight from the output table.
    function automatic logic [17:0] exp_vec(input int st, input logic ill);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn;
        logic [1:0] sb, aop, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, dn} = 11'b0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            1:  begin mr = 1'b1; irw = 1'b1; sb = 2'b01; pw = 1'b1; end
            2:  begin sb = 2'b11; end
            3:  begin sa = 1'b1; sb = 2'b10; end
            4:  begin mr = 1'b1; iod = 1'b1; end
            5:  begin m2r = 1'b1; rw = 1'b1; dn = 1'b1; end
            6:  begin mw = 1'b1; iod = 1'b1; dn = 1'b1; end
            7:  begin sa = 1'b1; aop = 2'b10; end
            8:  begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
            9:  begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 2'b01; dn = 1'b1; end
            10: begin pw = 1'b1; ps = 2'b10; dn = 1'b1; end
            11: begin sa = 1'b1; sb = 2'b10; end
            12: begin rw = 1'b1; dn = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, dn, ill};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (state !== 4'd0 || obs_vec !== 18'd0) begin
                failures++;
                $display("FAIL reset_hold cycle %0d: state=%0d outs=%b, expected state=0 outs=0", i, state, obs_vec);
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if (state !== 4'd1 || obs_vec !== exp_vec(1, 1'b0)) begin
            failures++;
            $display("FAIL reset_release: state=%0d outs=%b, expected state=1 outs=%b", state, obs_vec, exp_vec(1, 1'b0));
        end
    endtask

    task automatic test_lw();
        int exp_st [5];
        exp_st = '{1, 2, 3, 4, 5};
        opcode = 6'b100011;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== 4'(exp_st[i]) || obs_vec !== exp_vec(exp_st[i], 1'b0)) begin
                failures++;
                $display("FAIL lw_seq step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, obs_vec, exp_st[i], exp_vec(exp_st[i], 1'b0));
            end
            step();
        end
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL lw_return: state=%0d, expected 1", state);
        end
    endtask

    task automatic test_rtype();
        int exp_st [4];
        exp_st = '{1, 2, 7, 8};
        opcode = 6'b000000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(exp_st[i]) || obs_vec !== exp_vec(exp_st[i], 1'b0)) begin
                failures++;
                $display("FAIL rtype_seq step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, obs_vec, exp_st[i], exp_vec(exp_st[i], 1'b0));
            end
            step();
        end
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL rtype_return: state=%0d, expected 1", state);
        end
    endtask

    task automatic test_beq_j();
        int exp_st [3];
        exp_st = '{1, 2, 9};
        opcode = 6'b000100;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'(exp_st[i]) || obs_vec !== exp_vec(exp_st[i], 1'b0)) begin
                failures++;
                $display("FAIL beq_seq step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, obs_vec, exp_st[i], exp_vec(exp_st[i], 1'b0));
            end
            step();
        end
        exp_st = '{1, 2, 10};
        opcode = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== 4'(exp_st[i]) || obs_vec !== exp_vec(exp_st[i], 1'b0)) begin
                failures++;
                $display("FAIL j_seq step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, obs_vec, exp_st[i], exp_vec(exp_st[i], 1'b0));
            end
            step();
        end
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL j_return: state=%0d, expected 1", state);
        end
    endtask

    task automatic test_sw_opcode_change();
        int   exp_st [4];
        logic rw_seen;
        exp_st  = '{1, 2, 3, 6};
        rw_seen = 1'b0;
        opcode  = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(exp_st[i]) || obs_vec !== exp_vec(exp_st[i], 1'b0)) begin
                failures++;
                $display("FAIL sw_seq step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, obs_vec, exp_st[i], exp_vec(exp_st[i], 1'b0));
            end
            rw_seen = rw_seen | reg_write;
            if (i == 2) begin
                opcode = 6'b000000;
            end
            step();
        end
        checks++;
        if (rw_seen !== 1'b0 || state !== 4'd1) begin
            failures++;
            $display("FAIL sw_no_regwrite: reg_write_seen=%b state=%0d, expected 0 and 1", rw_seen, state);
        end
    endtask

    task automatic test_illegal();
        opcode = 6'b111111;
        checks++;
        if (state !== 4'd1 || illegal_op !== 1'b0) begin
            failures++;
            $display("FAIL illegal_fetch: state=%0d illegal_op=%b, expected 1 and 0", state, illegal_op);
        end
        step();
        checks++;
        if (state !== 4'd2 || obs_vec !== exp_vec(2, 1'b1)) begin
            failures++;
            $display("FAIL illegal_decode: state=%0d outs=%b, expected state=2 outs=%b", state, obs_vec, exp_vec(2, 1'b1));
        end
        step();
        checks++;
        if (state !== 4'd1 || obs_vec !== exp_vec(1, 1'b0)) begin
            failures++;
            $display("FAIL illegal_return: state=%0d outs=%b, expected state=1 outs=%b", state, obs_vec, exp_vec(1, 1'b0));
        end
    endtask

    task automatic test_addi();
`ifdef MC_ADDI_EN
        int exp_st [4];
        exp_st = '{1, 2, 11, 12};
        opcode = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(exp_st[i]) || obs_vec !== exp_vec(exp_st[i], 1'b0)) begin
                failures++;
                $display("FAIL addi_seq step %0d: state=%0d outs=%b, expected state=%0d outs=%b", i, state, obs_vec, exp_st[i], exp_vec(exp_st[i], 1'b0));
            end
            step();
        end
`else
        opcode = 6'b001000;
        step();
        checks++;
        if (state !== 4'd2 || obs_vec !== exp_vec(2, 1'b1)) begin
            failures++;
            $display("FAIL addi_illegal: state=%0d outs=%b, expected state=2 outs=%b", state, obs_vec, exp_vec(2, 1'b1));
        end
        step();
`endif
        checks++;
        if (state !== 4'd1) begin
            failures++;
            $display("FAIL addi_return: state=%0d, expected 1", state);
        end
    endtask

    task automatic test_reset_mid_lw();
        int   exp_st [4];
        logic rw_seen;
        exp_st  = '{1, 2, 3, 4};
        rw_seen = 1'b0;
        opcode  = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (state !== 4'(exp_st[i])) begin
                failures++;
                $display("FAIL midreset_seq step %0d: state=%0d, expected %0d", i, state, exp_st[i]);
            end
            rw_seen = rw_seen | reg_write;
            if (i < 3) begin
                step();
            end
        end
        reset = 1'b1;
        step();
        rw_seen = rw_seen | reg_write;
        checks++;
        if (state !== 4'd0 || obs_vec !== 18'd0) begin
            failures++;
            $display("FAIL midreset_idle: state=%0d outs=%b, expected state=0 outs=0", state, obs_vec);
        end
        reset = 1'b0;
        step();
        rw_seen = rw_seen | reg_write;
        checks++;
        if (state !== 4'd1 || rw_seen !== 1'b0) begin
            failures++;
            $display("FAIL midreset_refetch: state=%0d reg_write_seen=%b, expected 1 and 0", state, rw_seen);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq_j();
        test_sw_opcode_change();
        test_illegal();
        test_addi();
        test_reset_mid_lw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main control unit; sits directly upstream of the ALU.
- Decodes the 6-bit instruction opcode and sequences fetch/decode/execute/memory/writeback one state per clock.
- Drives ALUOp (00 add for lw/sw/PC, 01 subtract/compare for beq, 10 funct-field decode) plus all datapath mux, memory and register-file enables.
- Outputs are Moore: a pure decode of the current state register.

Parameters:
- OPCODE_W, 6, opcode width.
- STATE_W, 4, state register width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the instruction register; sampled only in DECODE.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination register: 0=rt, 1=rd.
- reg_write  out  1  register-file write enable.
- alu_src_a  out  1  0=PC, 1=register A.
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- alu_op  out  2  00 add, 01 sub/beq, 10 functions.
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- done  out  1  high in the final state of every instruction.
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- state  out  STATE_W  current state, for debug.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12.
- Reset: reset high at a clock edge forces state=IDLE, including mid-instruction (instruction is abandoned, no further writes).
  - IDLE drives every output 0. state=0.
  - IDLE to FETCH on the first edge with reset low.
- Output values per state (any output not listed is 0):
  - FETCH: mem_read=1, ir_write=1, alu_src_b=01, alu_op=00, pc_write=1, pc_source=00.
  - DECODE: alu_src_b=11, alu_op=00.
  - MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00.
  - MEM_READ: mem_read=1, i_or_d=1.
  - MEM_WB: mem_to_reg=1, reg_write=1, done=1.
  - MEM_WRITE: mem_write=1, i_or_d=1, done=1.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10.
  - R_WB: reg_dst=1, reg_write=1, done=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, done=1.
  - JUMP: pc_write=1, pc_source=10, done=1.
- Transitions:
  - FETCH to DECODE.
  - DECODE by opcode:
    - 100011 (lw) or 101011 (sw) to MEM_ADDR.
    - 000000 (R-type) to EXECUTE.
    - 000100 (beq) to BRANCH.
    - 000010 (j) to JUMP.
    - Any other opcode: illegal_op=1 for that cycle, then FETCH.
  - MEM_ADDR to MEM_READ if lw, MEM_WRITE if sw. The opcode captured in DECODE is held internally, so opcode changes after DECODE are ignored.
  - MEM_READ to MEM_WB. EXECUTE to R_WB.
  - MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP to FETCH.
- Latency, FETCH through done state inclusive: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2 (no done).
- Exactly one of reg_write, mem_write, pc_write_cond is high in any done state, except JUMP, which drives pc_write instead.
- Undefined state encodings (13-15) go to IDLE on the next edge with all outputs 0.

Optional Feature:
- MC_ADDI_EN defined:
  - Opcode 001000 (addi) goes DECODE to ADDI_EXEC to ADDI_WB to FETCH.
  - ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, done=1.
  - addi latency is 4.
- MC_ADDI_EN undefined:
  - Opcode 001000 is illegal (illegal_op pulse, back to FETCH).
  - ADDI_EXEC and ADDI_WB encodings are treated as undefined states.

Decomposition:
- Package mc_ctrl_pkg holds:
  - State encodings.
  - Opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI).
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10), shared with the ALU.
  - alu_src_b and pc_source select codes.
- One sub-module, mc_ctrl_decode: purely combinational state-to-outputs decode. The top holds the state register, the captured opcode and next-state logic.

Test Plan:
- Reset held 3 cycles, then released -> state=0 and all outputs 0 while held; state=1 (FETCH) one edge after release, with mem_read=ir_write=pc_write=1.
- lw (100011) -> states 1,2,3,4,5; alu_op=00 in states 1-3; done and reg_write high only in state 5 with mem_to_reg=1; back to 1.
- R-type (000000) -> states 1,2,7,8; alu_op=10 in EXECUTE; reg_dst=1 and reg_write=1 in R_WB. beq (000100) -> states 1,2,9 with alu_op=01 and pc_write_cond=1.
- sw with opcode changed to 000000 during MEM_ADDR -> still MEM_WRITE (state 6) with mem_write=1, i_or_d=1; no reg_write in any cycle.
- Opcode 111111 -> illegal_op=1 in DECODE only, next state FETCH. Opcode 001000 -> state 11 then 12 with MC_ADDI_EN defined; illegal_op=1 without it.
- reset asserted during MEM_READ of lw -> next state IDLE, MEM_WB never reached, reg_write never asserted.
